// File: rtl/link_arbiter_if.sv
// Bundle of requester-side and slave-side handshake signals around link_arbiter.
// The arbiter connects through the "slave" modport (it serves the requesters);
// the surrounding environment drives the "master" modport.
interface link_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        m_req;
  logic [NUM_REQ*DATA_W-1:0] m_data;
  logic [NUM_REQ-1:0]        m_last;
  logic [NUM_REQ-1:0]        m_ack;
  logic                      s_req;
  logic [DATA_W-1:0]         s_data;
  logic                      s_ack;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      err;

  modport master (
    output m_req, m_data, m_last, s_ack,
    input  m_ack, s_req, s_data, grant, busy, err
  );

  modport slave (
    input  m_req, m_data, m_last, s_ack,
    output m_ack, s_req, s_data, grant, busy, err
  );
endinterface

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link between NUM_REQ requesters.
// Grant is held for a whole burst (terminated by m_last) so bytes never interleave.
// Optional watchdog: define LINK_ARB_TIMEOUT_EN to build the TIMEOUT_CYC abort counter;
// without it err is tied low and the arbiter waits indefinitely.
module link_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic           clk,
  input logic           rst,
  link_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("link_arbiter: NUM_REQ must be in 2..4");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("link_arbiter: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StXfer, StAckd, StHold} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     sel_q;
  logic                last_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  m_ack_q;
  logic                s_req_q;
  logic [DATA_W-1:0]   s_data_q;
  logic                busy_q;

  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW:0]       cand_sum;
  logic                advance;
  logic                timeout;
  logic [IdxW-1:0]     ptr_next;

  // Cyclic search for the first requester at or after ptr; walking downwards lets the
  // candidate closest to ptr win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + (IdxW + 1)'(k);
      if (cand_sum >= (IdxW + 1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IdxW + 1)'(NUM_REQ);
      end
      if (bus.m_req[cand_sum[IdxW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_sum[IdxW-1:0];
      end
    end
  end

  // Exit condition of the current state; shared by the FSM and the watchdog.
  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      StIdle:  advance = pick_valid;
      StXfer:  advance = bus.s_ack;
      StAckd:  advance = !bus.m_req[sel_q] && !bus.s_ack;
      StHold:  advance = bus.m_req[sel_q];
      default: advance = 1'b0;
    endcase
  end

  assign ptr_next = (sel_q == IdxW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef LINK_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // Cycles spent in the current non-idle state; any transition restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == StIdle || advance || timeout) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // True on the edge where the count would reach TIMEOUT_CYC.
  assign timeout = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Arbitration and handshake FSM; every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      sel_q    <= '0;
      last_q   <= 1'b0;
      grant_q  <= '0;
      m_ack_q  <= '0;
      s_req_q  <= 1'b0;
      s_data_q <= '0;
      busy_q   <= 1'b0;
    end else if (timeout) begin
      // Watchdog abort: drop the link and move priority past the stuck owner.
      state_q <= StIdle;
      s_req_q <= 1'b0;
      m_ack_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= ptr_next;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (advance) begin
            sel_q    <= pick_idx;
            grant_q  <= NUM_REQ'(1) << pick_idx;
            s_data_q <= bus.m_data[pick_idx*DATA_W +: DATA_W];
            last_q   <= bus.m_last[pick_idx];
            s_req_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StXfer;
          end
        end
        StXfer: begin
          // s_req stays up until the slave acks, even if the requester withdraws.
          if (advance) begin
            s_req_q        <= 1'b0;
            m_ack_q[sel_q] <= 1'b1;
            state_q        <= StAckd;
          end
        end
        StAckd: begin
          if (advance) begin
            m_ack_q <= '0;
            if (last_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= ptr_next;
              state_q <= StIdle;
            end else begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          // Only the owner can continue; everyone else keeps m_req up and waits.
          if (advance) begin
            s_data_q <= bus.m_data[sel_q*DATA_W +: DATA_W];
            last_q   <= bus.m_last[sel_q];
            s_req_q  <= 1'b1;
            state_q  <= StXfer;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_ack  = m_ack_q;
  assign bus.s_req  = s_req_q;
  assign bus.s_data = s_data_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter with two requesters: a per-cycle vector table covering
// bursts, HOLD behaviour, round-robin priority and a dropped request, plus hand-written
// sequences for alternation, slow slave, asynchronous reset and the optional watchdog.
module tb_link_arbiter;
  localparam int unsigned NumReq = 2;
  localparam int unsigned DataW  = 8;
`ifdef LINK_ARB_TIMEOUT_EN
  localparam int unsigned ToCyc  = 20;
`else
  localparam int unsigned ToCyc  = 255;
`endif
  localparam int unsigned NumVec = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;

  link_arbiter_if #(.NUM_REQ(NumReq), .DATA_W(DataW)) bus ();

  link_arbiter #(
    .NUM_REQ    (NumReq),
    .DATA_W     (DataW),
    .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sack;
    logic [1:0] mack;
    logic       sreq;
    logic [7:0] sdata;
    logic [1:0] grant;
    logic       busy;
  } vec_t;

  vec_t tbl [NumVec];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] last, input logic [7:0] d0,
                       input logic [7:0] d1, input logic sack);
    bus.m_req  = req;
    bus.m_last = last;
    bus.m_data = {d1, d0};
    bus.s_ack  = sack;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {m_ack, s_req, s_data, grant, busy, err}
  function automatic logic [31:0] outs();
    return {17'd0, bus.m_ack, bus.s_req, bus.s_data, bus.grant, bus.busy, bus.err};
  endfunction

  initial begin
    logic [1:0] w;
    int         n;

    //          req    last   d0     d1     sack  mack   sreq  sdata  grant  busy
    tbl[0]  = '{2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA1, 2'b01, 1'b1};
    tbl[1]  = '{2'b01, 2'b00, 8'hA1, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA1, 2'b01, 1'b1};
    tbl[2]  = '{2'b00, 2'b00, 8'hA1, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA1, 2'b01, 1'b1};
    tbl[3]  = '{2'b01, 2'b00, 8'hA2, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA2, 2'b01, 1'b1};
    tbl[4]  = '{2'b01, 2'b00, 8'hA2, 8'h00, 1'b0, 2'b00, 1'b1, 8'hA2, 2'b01, 1'b1};
    tbl[5]  = '{2'b01, 2'b00, 8'hA2, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA2, 2'b01, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 8'hA2, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA2, 2'b01, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 8'hA2, 8'h00, 1'b0, 2'b00, 1'b0, 8'hA2, 2'b01, 1'b1};
    tbl[8]  = '{2'b10, 2'b00, 8'hA2, 8'hB1, 1'b0, 2'b00, 1'b0, 8'hA2, 2'b01, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 8'hA3, 8'hB1, 1'b0, 2'b00, 1'b1, 8'hA3, 2'b01, 1'b1};
    tbl[10] = '{2'b11, 2'b00, 8'hA3, 8'hB1, 1'b1, 2'b01, 1'b0, 8'hA3, 2'b01, 1'b1};
    tbl[11] = '{2'b10, 2'b00, 8'hA3, 8'hB1, 1'b0, 2'b00, 1'b0, 8'hA3, 2'b01, 1'b1};
    tbl[12] = '{2'b11, 2'b01, 8'hA4, 8'hB1, 1'b0, 2'b00, 1'b1, 8'hA4, 2'b01, 1'b1};
    tbl[13] = '{2'b11, 2'b01, 8'hA4, 8'hB1, 1'b1, 2'b01, 1'b0, 8'hA4, 2'b01, 1'b1};
    tbl[14] = '{2'b10, 2'b00, 8'hA4, 8'hB1, 1'b0, 2'b00, 1'b0, 8'hA4, 2'b00, 1'b0};
    tbl[15] = '{2'b11, 2'b11, 8'hC0, 8'hB1, 1'b0, 2'b00, 1'b1, 8'hB1, 2'b10, 1'b1};
    tbl[16] = '{2'b11, 2'b11, 8'hC0, 8'hB1, 1'b1, 2'b10, 1'b0, 8'hB1, 2'b10, 1'b1};
    tbl[17] = '{2'b01, 2'b11, 8'hC0, 8'hB1, 1'b0, 2'b00, 1'b0, 8'hB1, 2'b00, 1'b0};
    tbl[18] = '{2'b01, 2'b11, 8'hC0, 8'hB1, 1'b0, 2'b00, 1'b1, 8'hC0, 2'b01, 1'b1};
    tbl[19] = '{2'b01, 2'b11, 8'hC0, 8'hB1, 1'b1, 2'b01, 1'b0, 8'hC0, 2'b01, 1'b1};
    tbl[20] = '{2'b00, 2'b00, 8'hC0, 8'hB1, 1'b0, 2'b00, 1'b0, 8'hC0, 2'b00, 1'b0};
    tbl[21] = '{2'b10, 2'b10, 8'hC0, 8'hD1, 1'b0, 2'b00, 1'b1, 8'hD1, 2'b10, 1'b1};
    tbl[22] = '{2'b00, 2'b10, 8'hC0, 8'hD1, 1'b0, 2'b00, 1'b1, 8'hD1, 2'b10, 1'b1};
    tbl[23] = '{2'b00, 2'b10, 8'hC0, 8'hD1, 1'b1, 2'b10, 1'b0, 8'hD1, 2'b10, 1'b1};
    tbl[24] = '{2'b00, 2'b00, 8'hC0, 8'hD1, 1'b0, 2'b00, 1'b0, 8'hD1, 2'b00, 1'b0};

    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b0;
    step();
    step();
    check("reset_state", outs(), 32'd0);
    rst = 1'b1;

    // Vector table: one clock per row, outputs checked just after the edge.
    for (int i = 0; i < int'(NumVec); i++) begin
      drive(tbl[i].req, tbl[i].last, tbl[i].d0, tbl[i].d1, tbl[i].sack);
      step();
      check($sformatf("vec%0d", i), outs(),
            {17'd0, tbl[i].mack, tbl[i].sreq, tbl[i].sdata, tbl[i].grant, tbl[i].busy, 1'b0});
    end

    // Round-robin alternation: both request single-byte bursts every round, ptr starts at 0.
    for (int r = 0; r < 4; r++) begin
      w = (r % 2 == 0) ? 2'b01 : 2'b10;
      drive(2'b11, 2'b11, 8'h10 + 8'(r), 8'h20 + 8'(r), 1'b0);
      step();
      check($sformatf("alt%0d_grant", r), {30'd0, bus.grant}, {30'd0, w});
      check($sformatf("alt%0d_data", r), {24'd0, bus.s_data},
            {24'd0, (w == 2'b01) ? 8'h10 + 8'(r) : 8'h20 + 8'(r)});
      drive(2'b11, 2'b11, 8'h10 + 8'(r), 8'h20 + 8'(r), 1'b1);
      step();
      check($sformatf("alt%0d_ack", r), {30'd0, bus.m_ack}, {30'd0, w});
      drive(~w, 2'b11, 8'h10 + 8'(r), 8'h20 + 8'(r), 1'b0);
      step();
      check($sformatf("alt%0d_idle", r), {29'd0, bus.grant, bus.busy}, 32'd0);
    end

    // Slow slave: s_req and s_data hold for 5 cycles while requester data changes.
    drive(2'b01, 2'b01, 8'hE5, 8'h00, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 2'b01, 8'h5A, 8'h00, 1'b0);
      step();
      check($sformatf("delay_hold%0d", k), outs(), {17'd0, 2'b00, 1'b1, 8'hE5, 2'b01, 1'b1, 1'b0});
    end
    drive(2'b01, 2'b01, 8'h5A, 8'h00, 1'b1);
    step();
    check("delay_ack", outs(), {17'd0, 2'b01, 1'b0, 8'hE5, 2'b01, 1'b1, 1'b0});
    drive(2'b00, 2'b00, 8'h5A, 8'h00, 1'b0);
    step();
    check("delay_idle", outs(), {17'd0, 2'b00, 1'b0, 8'hE5, 2'b00, 1'b0, 1'b0});

    // Reset in HOLD with ptr=1: outputs clear without a clock edge, ptr back to 0.
    drive(2'b01, 2'b00, 8'hF0, 8'h00, 1'b0);
    step();
    drive(2'b01, 2'b00, 8'hF0, 8'h00, 1'b1);
    step();
    drive(2'b00, 2'b00, 8'hF0, 8'h00, 1'b0);
    step();
    check("hold_before_rst", outs(), {17'd0, 2'b00, 1'b0, 8'hF0, 2'b01, 1'b1, 1'b0});
    #2 rst = 1'b0;
    #1 check("rst_async_hold", outs(), 32'd0);
    #2 rst = 1'b1;
    drive(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b0);
    step();
    check("rst_ptr_zero", outs(), {17'd0, 2'b00, 1'b1, 8'hC0, 2'b01, 1'b1, 1'b0});
    #2 rst = 1'b0;
    #1 check("rst_async_xfer", outs(), 32'd0);
    #2 rst = 1'b1;
    drive(2'b10, 2'b10, 8'h00, 8'hD2, 1'b0);
    step();
    check("rst_req1_grant", outs(), {17'd0, 2'b00, 1'b1, 8'hD2, 2'b10, 1'b1, 1'b0});
    drive(2'b10, 2'b10, 8'h00, 8'hD2, 1'b1);
    step();
    check("rst_req1_ack", {30'd0, bus.m_ack}, {30'd0, 2'b10});
    drive(2'b00, 2'b00, 8'h00, 8'hD2, 1'b0);
    step();
    check("rst_req1_idle", outs(), {17'd0, 2'b00, 1'b0, 8'hD2, 2'b00, 1'b0, 1'b0});

`ifdef LINK_ARB_TIMEOUT_EN
    // Watchdog: slave never acks; err pulses ToCyc cycles after XFER entry.
    drive(2'b01, 2'b01, 8'h77, 8'h88, 1'b0);
    step();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.err) begin
        n = i;
        break;
      end
    end
    check("to_cycles", n, ToCyc);
    check("to_abort", {27'd0, bus.grant, bus.s_req, bus.busy, bus.m_ack}, 32'd0);
    drive(2'b11, 2'b11, 8'h77, 8'h88, 1'b0);
    step();
    check("to_err_pulse", {31'd0, bus.err}, 32'd0);
    check("to_next", outs(), {17'd0, 2'b00, 1'b1, 8'h88, 2'b10, 1'b1, 1'b0});
    drive(2'b11, 2'b11, 8'h77, 8'h88, 1'b1);
    step();
    check("to_next_ack", {30'd0, bus.m_ack}, {30'd0, 2'b10});
    drive(2'b00, 2'b00, 8'h77, 8'h88, 1'b0);
    step();
`else
    n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
- Round-robin arbiter sharing one req/ack byte link (slave_fsm-style receiver) between NUM_REQ master_fsm-style requesters.
- Each requester uses a 4-phase req/ack handshake with an 8-bit data bus.
- Grant is held for a whole burst, delimited by a per-requester last flag, so bytes from different masters never interleave.
- Sits between the masters and the single slave inside the link top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 8, data bus width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- m_req  in  NUM_REQ  per-requester request
- m_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- m_last  in  NUM_REQ  sampled with m_req; marks the final byte of a burst
- m_ack  out  NUM_REQ  per-requester acknowledge
- s_req  out  1  request to slave
- s_data  out  DATA_W  byte to slave
- s_ack  in  1  acknowledge from slave
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- busy  out  1  high whenever state is not IDLE
- err  out  1  watchdog abort pulse (optional feature only; otherwise tied 0)

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): m_ack=0, s_req=0, s_data=0, grant=0, busy=0, err=0, state=IDLE, priority pointer ptr=0, last_q=0.
- States: IDLE, XFER, ACKD, HOLD.
- IDLE:
  - If any m_req is high, pick the first requester at or after ptr (cyclic search).
  - Next cycle: grant=one-hot(sel), s_data=m_data[sel], last_q=m_last[sel], s_req=1, go to XFER.
  - Request-to-s_req latency is exactly 1 cycle.
- XFER:
  - Hold s_req=1 and s_data stable until s_ack=1.
  - Then s_req=0, m_ack[sel]=1, go to ACKD.
- ACKD:
  - Wait until m_req[sel]=0 and s_ack=0 (both, in either order), then m_ack[sel]=0.
  - If last_q=1: grant=0, ptr=(sel+1) mod NUM_REQ, go to IDLE.
  - If last_q=0: go to HOLD.
- HOLD:
  - Grant stays with sel; other requests are ignored.
  - When m_req[sel]=1: capture m_data[sel] and m_last[sel], s_req=1, go to XFER.
- m_ack is only ever asserted for the granted index; non-granted m_ack stay 0.
- Simultaneous requests resolve by ptr only. Example: ptr=1, m_req=2'b11 → requester 1 wins.
- m_req[sel] dropping while in XFER (protocol violation): the transfer still completes; s_req is held until s_ack. ACKD then exits as soon as s_ack=0.
- New requests arriving in ACKD or HOLD are queued by the requester holding m_req; they are not lost.
- Reset mid-burst: all outputs drop immediately and ptr returns to 0. The slave sees s_req fall asynchronously.
- s_data changes only on entry to XFER.

Optional Feature:
- Macro: LINK_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on every state change and increments in XFER, ACKD and HOLD.
  - When it reaches TIMEOUT_CYC: s_req=0, all m_ack=0, grant=0, ptr advances past sel, state=IDLE, err=1 for exactly one cycle.
- When undefined: no counter is built, err is constant 0, and the arbiter waits indefinitely.

Test Plan:
- Single requester 0 sends a 4-byte burst 0xA1,0xA2,0xA3,0xA4 (last on 0xA4) → slave latches the bytes in order; grant=01 throughout; grant=0 and ptr=1 after the 4th ACKD.
- Both requesters raise m_req in the same cycle after reset → requester 0 served first. Requester 1's 2-byte burst 0xB1,0xB2 starts only after requester 0's last byte; no interleaving of bytes on s_data.
- Requester 1 finishes, then both request again → requester 0 wins (ptr=0). Repeat 4 rounds → grants alternate 0,1,0,1.
- Slave delays s_ack by 5 cycles → s_req held high and s_data stable for all 5 cycles; m_ack rises 1 cycle after s_ack.
- rst pulsed low in the middle of HOLD → all outputs 0 without waiting for a clock edge. After release, a request from requester 1 gets grant=10 one cycle later.
- With LINK_ARB_TIMEOUT_EN and TIMEOUT_CYC=20, slave never acks → err pulses once, 20 cycles after XFER entry; grant=0; the next requester is then served normally.
